fd_branch_stage: RTL and testbench

//  IF/ID pipeline register plus decode-stage branch resolution. Latches the
//  32-bit fetch bundle {pc_plus_2, instruction}, resolves B/BR in D, returns

---
 rtl/fd_branch_stage_if.sv | 23 ++
 rtl/fd_branch_stage.sv | 69 ++++++
 tb/tb_fd_branch_stage.sv | 117 +++++++++++
 3 files changed

// File: rtl/fd_branch_stage_if.sv
// fd_branch_stage_if: fetch/decode bundle between fetch, hazard unit and the branch stage
interface fd_branch_stage_if #(parameter int DW = 16, parameter int CNT_W = 16);
  logic [2*DW-1:0] f_in;
  logic            stall;
  logic [2:0]      flags;
  logic [DW-1:0]   rs_data;
  logic [DW-1:0]   d_pc_plus_2;
  logic [DW-1:0]   d_instr;
  logic            d_valid;
  logic            flush;
  logic [DW-1:0]   branch_target;
  logic            halt_seen;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] br_taken_count;
  modport master (
    output f_in, stall, flags, rs_data,
    input  d_pc_plus_2, d_instr, d_valid, flush, branch_target, halt_seen, br_count, br_taken_count
  );
  modport slave (
    input  f_in, stall, flags, rs_data,
    output d_pc_plus_2, d_instr, d_valid, flush, branch_target, halt_seen, br_count, br_taken_count
  );
endinterface

// File: rtl/fd_branch_stage.sv
// fd_branch_stage: IF/ID register with decode-stage branch resolution, halt tracking and branch counters
module fd_branch_stage #(
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  fd_branch_stage_if.slave fd
);
  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] pc_q, pc_d, instr_q, instr_d, target;
  logic [CNT_W-1:0] br_q, br_d, tk_q, tk_d;
  logic valid_q, valid_d, is_b, is_br, cond_true, run, resolve, flush, halt_now, hold;
  logic n, z, v;
  logic [7:0] cond_vec;
  assign {n, z, v} = fd.flags;
  assign is_b      = instr_q[15:12] == 4'hC;
  assign is_br     = instr_q[15:12] == 4'hD;
  // Indexed by the 3-bit condition field
  assign cond_vec  = {1'b1, v, n | z, z | (~z & ~n), n, ~z & ~n, z, ~z};
  assign cond_true = cond_vec[instr_q[11:9]];
  assign run       = state_q == RUN;
  assign resolve   = valid_q & (is_b | is_br) & ~fd.stall & run;
  assign flush     = resolve & cond_true;
  assign target    = is_b ? pc_q + {{(DW-10){instr_q[8]}}, instr_q[8:0], 1'b0} : fd.rs_data;
  assign halt_now  = run & valid_q & (instr_q[15:12] == 4'hF) & ~fd.stall;
  assign hold      = ~run | halt_now | fd.stall;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = halt_now ? HALTED : state_q;
  end
  always_comb begin
    fd.halt_seen = state_q == HALTED;
  end
  always_comb begin
    pc_d    = hold ? pc_q : flush ? '0 : fd.f_in[2*DW-1:DW];
    instr_d = hold ? instr_q : flush ? '0 : fd.f_in[DW-1:0];
    // The HLT leaving D is the last valid instruction; nothing behind it is real
    valid_d = (~run | halt_now) ? 1'b0 : fd.stall ? valid_q : ~flush;
    br_d    = (resolve & ~&br_q) ? br_q + CNT_W'(1) : br_q;
    tk_d    = (flush & ~&tk_q) ? tk_q + CNT_W'(1) : tk_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      br_q    <= '0;
      tk_q    <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      br_q    <= br_d;
      tk_q    <= tk_d;
    end
  end
  assign fd.d_pc_plus_2    = pc_q;
  assign fd.d_instr        = instr_q;
  assign fd.d_valid        = valid_q;
  assign fd.flush          = flush;
  assign fd.branch_target  = flush ? target : '0;
  assign fd.br_count       = br_q;
  assign fd.br_taken_count = tk_q;
endmodule

// File: tb/tb_fd_branch_stage.sv
// tb_fd_branch_stage: directed vectors with a queued scoreboard checked by a negedge monitor
module tb_fd_branch_stage;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  int ncyc = 0;
  typedef struct {
    string       name;
    logic [15:0] pc, instr;
    logic        valid, flush;
    logic [15:0] tgt;
    logic        halt;
    logic [15:0] brc, tkc;
    int          at;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [82:0] act, req;
  fd_branch_stage_if #(.DW(16), .CNT_W(16)) fd ();
  fd_branch_stage #(.DW(16), .CNT_W(16)) dut (.clk(clk), .rst(rst), .fd(fd));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at == ncyc) begin
      e   = q.pop_front();
      act = {fd.d_pc_plus_2, fd.d_instr, fd.d_valid, fd.flush, fd.branch_target,
             fd.halt_seen, fd.br_count, fd.br_taken_count};
      req = {e.pc, e.instr, e.valid, e.flush, e.tgt, e.halt, e.brc, e.tkc};
      total++;
      if (act !== req) begin
        bad++;
        $display("FAIL %s: got pc=%h ins=%h v=%b fl=%b tgt=%h h=%b bc=%0d tc=%0d, want pc=%h ins=%h v=%b fl=%b tgt=%h h=%b bc=%0d tc=%0d",
                 e.name, fd.d_pc_plus_2, fd.d_instr, fd.d_valid, fd.flush, fd.branch_target,
                 fd.halt_seen, fd.br_count, fd.br_taken_count,
                 e.pc, e.instr, e.valid, e.flush, e.tgt, e.halt, e.brc, e.tkc);
      end
    end
    ncyc++;
  end
  task automatic step(input logic [31:0] f, input logic st, input logic [2:0] fl, input logic [15:0] rs);
    @(posedge clk);
    #1;
    fd.f_in    = f;
    fd.stall   = st;
    fd.flags   = fl;
    fd.rs_data = rs;
  endtask
  task automatic chk(input string n, input logic [15:0] pc, input logic [15:0] ins, input logic v,
                     input logic fl, input logic [15:0] tg, input logic h, input logic [15:0] bc,
                     input logic [15:0] tc);
    exp_t x;
    x.name = n; x.pc = pc; x.instr = ins; x.valid = v; x.flush = fl; x.tgt = tg;
    x.halt = h; x.brc = bc; x.tkc = tc; x.at = ncyc;
    q.push_back(x);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    fd.f_in = '0; fd.stall = 1'b0; fd.flags = '0; fd.rs_data = '0;
    chk("reset", 16'h0, 16'h0, 0, 0, 16'h0, 0, 0, 0);
    step(32'h0002_1123, 0, 3'b000, 16'h0000); rst = 1'b0;
    chk("rst_rel", 16'h0, 16'h0, 0, 0, 16'h0, 0, 0, 0);
    step(32'h0010_CE04, 0, 3'b000, 16'h0000);
    chk("T1_load", 16'h0002, 16'h1123, 1, 0, 16'h0, 0, 0, 0);
    step(32'h0012_0000, 0, 3'b000, 16'h0000);
    chk("T2_flush", 16'h0010, 16'hCE04, 1, 1, 16'h0018, 0, 0, 0);
    step(32'h0020_D250, 0, 3'b000, 16'h0040);
    chk("T2_bubble", 16'h0, 16'h0, 0, 0, 16'h0, 0, 1, 1);
    step(32'h0022_1180, 0, 3'b000, 16'h0040);
    chk("T3_br_nt", 16'h0020, 16'hD250, 1, 0, 16'h0, 0, 1, 1);
    step(32'h0030_D250, 0, 3'b010, 16'h0040);
    chk("T3_nonbr", 16'h0022, 16'h1180, 1, 0, 16'h0, 0, 2, 1);
    step(32'h0032_0000, 0, 3'b010, 16'h0040);
    chk("T3_br_tk", 16'h0030, 16'hD250, 1, 1, 16'h0040, 0, 2, 1);
    step(32'h0040_CE04, 0, 3'b000, 16'h0000);
    chk("T3_bubble", 16'h0, 16'h0, 0, 0, 16'h0, 0, 3, 2);
    for (int i = 1; i <= 3; i++) begin
      step(32'h0042_1111, 1, 3'b000, 16'h0000);
      chk($sformatf("T4_stall%0d", i), 16'h0040, 16'hCE04, 1, 0, 16'h0, 0, 3, 2);
    end
    step(32'h0042_1111, 0, 3'b000, 16'h0000);
    chk("T4_release", 16'h0040, 16'hCE04, 1, 1, 16'h0048, 0, 3, 2);
    step(32'h0004_CF00, 0, 3'b000, 16'h0000);
    chk("T4_once", 16'h0, 16'h0, 0, 0, 16'h0, 0, 4, 3);
    step(32'h0006_1234, 0, 3'b000, 16'h0000);
    chk("T5_wrap", 16'h0004, 16'hCF00, 1, 1, 16'hFE04, 0, 4, 3);
    step(32'h0008_F000, 0, 3'b000, 16'h0000);
    chk("T5_bubble", 16'h0, 16'h0, 0, 0, 16'h0, 0, 5, 4);
    step(32'h000A_1234, 1, 3'b000, 16'h0000);
    chk("T6_hlt", 16'h0008, 16'hF000, 1, 0, 16'h0, 0, 5, 4);
    step(32'h000A_1234, 0, 3'b000, 16'h0000);
    chk("T6_hlt_stall", 16'h0008, 16'hF000, 1, 0, 16'h0, 0, 5, 4);
    step(32'h000C_CE04, 0, 3'b000, 16'h0000);
    chk("T6_halted", 16'h0008, 16'hF000, 0, 0, 16'h0, 1, 5, 4);
    step(32'h000C_CE04, 0, 3'b000, 16'h0000);
    chk("T6_halted2", 16'h0008, 16'hF000, 0, 0, 16'h0, 1, 5, 4);
    @(posedge clk); #1; rst = 1'b1;
    chk("T6_rst_async", 16'h0, 16'h0, 0, 0, 16'h0, 0, 0, 0);
    step(32'h0002_1123, 0, 3'b000, 16'h0000); rst = 1'b0;
    chk("T6_rst_hold", 16'h0, 16'h0, 0, 0, 16'h0, 0, 0, 0);
    step(32'h0002_1123, 0, 3'b000, 16'h0000);
    chk("post_rst_load", 16'h0002, 16'h1123, 1, 0, 16'h0, 0, 0, 0);
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      $display("FAIL drain: pending=%0d want 0", q.size());
      bad += q.size();
      total += q.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
